cpu_icache: RTL and testbench

- Direct-mapped, read-only instruction cache. It is the responder to the fetch stage's lookup port (enable + PC in; hit + instruction out).
- A lookup is combinational against registered tag/valid/data arrays. Fetch can therefore sample hit and instruction in the same cycle it drives the PC.
- On a miss, a fill FSM fetches the 4 instruction bytes through the byte-wide memory arbiter port and installs the line.

---
 rtl/cpu_icache_if.sv | 21 ++
 rtl/cpu_icache.sv | 124 ++++++++++++
 tb/tb_cpu_icache.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_icache_if.sv
// Fetch lookup port and byte-wide memory arbiter port of the instruction cache.
interface cpu_icache_if;
  logic        en_rx;
  logic [31:0] pcx;
  logic        hitx;
  logic [31:0] instx;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_din;

  modport slave (
    input  en_rx, pcx, mem_gnt, mem_din,
    output hitx, instx, mem_req, mem_addr
  );

  modport master (
    output en_rx, pcx, mem_gnt, mem_din,
    input  hitx, instx, mem_req, mem_addr
  );
endinterface

// File: rtl/cpu_icache.sv
// Direct-mapped read-only instruction cache: combinational lookup against
// registered arrays, with a miss fill fetching 4 bytes over the arbiter port.
module cpu_icache #(
  parameter int unsigned INDEX_BITS = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  cpu_icache_if.slave  bus
);

  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;
  localparam int unsigned LINES    = 1 << INDEX_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state, state_nxt;
  logic [31:0]           miss_pc;
  logic [2:0]            issue_cnt;
  logic [1:0]            recv_cnt;
  logic                  pending;
  logic [31:0]           fill_buf;
  logic [31:0]           fill_word;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_arr  [LINES];
  logic [31:0]           data_arr [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  line_valid;
  logic                  miss_take;
  logic                  issue_fire;
  logic                  capture;
  logic                  fill_done;

  assign idx      = bus.pcx[INDEX_BITS+1:2];
  assign tag      = bus.pcx[31:INDEX_BITS+2];
  assign miss_idx = miss_pc[INDEX_BITS+1:2];

  // Lookup; reset masks the arrays so nothing hits while it is held.
  always_comb begin
    line_valid = valid[idx] & ~rst;
    bus.hitx   = bus.en_rx & line_valid & (tag_arr[idx] == tag);
    bus.instx  = line_valid ? data_arr[idx] : 32'h0;
  end

  // Fill FSM next-state and request generation.
  always_comb begin
    state_nxt    = state;
    bus.mem_req  = 1'b0;
    bus.mem_addr = miss_pc + 32'(issue_cnt);
    miss_take    = 1'b0;
    capture      = 1'b0;
    fill_done    = 1'b0;
    case (state)
      IDLE: begin
        miss_take = rdy & bus.en_rx & ~bus.hitx;
        if (miss_take) state_nxt = FILL;
      end
      FILL: begin
        bus.mem_req = rdy & ~issue_cnt[2];
        capture     = pending;
        fill_done   = pending & (recv_cnt == 2'd3);
        if (fill_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      bus.mem_req = 1'b0;
      miss_take   = 1'b0;
      capture     = 1'b0;
      fill_done   = 1'b0;
    end
    issue_fire = bus.mem_req & bus.mem_gnt;
  end

  // Merge the returning byte into its lane (lane 0 is the most significant).
  always_comb begin
    fill_word = fill_buf;
    case (recv_cnt)
      2'd0:    fill_word[31:24] = bus.mem_din;
      2'd1:    fill_word[23:16] = bus.mem_din;
      2'd2:    fill_word[15:8]  = bus.mem_din;
      default: fill_word[7:0]   = bus.mem_din;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Fill counters and valid bits; a miss invalidates its line until refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= 3'd0;
      recv_cnt  <= 2'd0;
      pending   <= 1'b0;
      valid     <= '0;
    end else begin
      pending <= issue_fire;
      if (miss_take) begin
        issue_cnt  <= 3'd0;
        recv_cnt   <= 2'd0;
        valid[idx] <= 1'b0;
      end
      if (issue_fire) issue_cnt <= issue_cnt + 3'd1;
      if (capture)    recv_cnt  <= recv_cnt + 2'd1;
      if (fill_done)  valid[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (miss_take) miss_pc  <= {bus.pcx[31:2], 2'b00};
    if (capture)   fill_buf <= fill_word;
    if (fill_done) begin
      data_arr[miss_idx] <= fill_word;
      tag_arr[miss_idx]  <= miss_pc[31:INDEX_BITS+2];
    end
  end

endmodule

// File: tb/tb_cpu_icache.sv
// Directed bench for cpu_icache with a byte-wide memory model behind the arbiter port.
module tb_cpu_icache;

  logic clk;
  logic rst;
  logic rdy;
  int   n_vec;
  int   n_err;

  cpu_icache_if ifc ();

  cpu_icache dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h000: return 8'h13;
      32'h001: return 8'h05;
      32'h002: return 8'h00;
      32'h003: return 8'h00;
      32'h004: return 8'h11;
      32'h005: return 8'h22;
      32'h006: return 8'h33;
      32'h007: return 8'h44;
      32'h008: return 8'hDE;
      32'h009: return 8'hAD;
      32'h00A: return 8'hBE;
      32'h00B: return 8'hEF;
      32'h040: return 8'h93;
      32'h041: return 8'h00;
      32'h042: return 8'h10;
      32'h043: return 8'h00;
      32'h200: return 8'hAA;
      32'h201: return 8'hBB;
      32'h202: return 8'hCC;
      32'h203: return 8'hDD;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Memory returns the granted byte on the cycle after the accepting edge.
  always @(posedge clk)
    ifc.mem_din <= (ifc.mem_req && ifc.mem_gnt) ? mem_byte(ifc.mem_addr) : 8'h5A;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hit(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = ifc.hitx;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    rdy         = 1'b1;
    ifc.en_rx   = 1'b0;
    ifc.pcx     = 32'h0;
    ifc.mem_gnt = 1'b1;
    tick();
    tick();
    chk("rst_hit", 32'(ifc.hitx), 32'd0);
    chk("rst_req", 32'(ifc.mem_req), 32'd0);
    chk("rst_inst", ifc.instx, 32'h0);
    rst = 1'b0;
    tick();

    // Cold miss at 0x0: addresses 0..3, hit exactly 5 cycles after the miss edge.
    ifc.en_rx = 1'b1;
    ifc.pcx   = 32'h0;
    #1;
    chk("cold_miss", 32'(ifc.hitx), 32'd0);
    chk("cold_idle_req", 32'(ifc.mem_req), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cold_req%0d", k), 32'(ifc.mem_req), 32'd1);
      chk($sformatf("cold_addr%0d", k), ifc.mem_addr, 32'(k));
      chk($sformatf("cold_nohit%0d", k), 32'(ifc.hitx), 32'd0);
      tick();
    end
    chk("cold_req_done", 32'(ifc.mem_req), 32'd0);
    chk("cold_nohit4", 32'(ifc.hitx), 32'd0);
    tick();
    chk("cold_hit", 32'(ifc.hitx), 32'd1);
    chk("cold_inst", ifc.instx, 32'h13050000);

    // Repeat hit with no request.
    tick();
    chk("rep_hit", 32'(ifc.hitx), 32'd1);
    chk("rep_req", 32'(ifc.mem_req), 32'd0);

    // Fill 0x4 for later hit-under-miss.
    ifc.pcx = 32'h4;
    wait_hit("fill4_hit");
    chk("fill4_inst", ifc.instx, 32'h11223344);

    // Conflict miss at 0x200 with hit-under-miss and redirect mid-fill.
    ifc.pcx = 32'h200;
    #1;
    chk("conf_miss", 32'(ifc.hitx), 32'd0);
    tick();
    chk("conf_addr0", ifc.mem_addr, 32'h200);
    ifc.pcx = 32'h4;
    #1;
    chk("hum_hit", 32'(ifc.hitx), 32'd1);
    chk("hum_inst", ifc.instx, 32'h11223344);
    tick();
    ifc.pcx = 32'h0;
    #1;
    chk("under_fill_miss", 32'(ifc.hitx), 32'd0);
    chk("conf_addr1", ifc.mem_addr, 32'h201);
    tick();
    ifc.pcx = 32'h40;
    #1;
    chk("redir_addr2", ifc.mem_addr, 32'h202);
    tick();
    chk("redir_addr3", ifc.mem_addr, 32'h203);
    tick();
    tick();
    chk("conf_back_idle", 32'(ifc.mem_req), 32'd0);
    ifc.pcx = 32'h200;
    #1;
    chk("conf_hit", 32'(ifc.hitx), 32'd1);
    chk("conf_inst", ifc.instx, 32'hAABBCCDD);
    ifc.pcx = 32'h0;
    #1;
    chk("evict_miss", 32'(ifc.hitx), 32'd0);
    ifc.pcx = 32'h40;
    tick();
    chk("redir_req", 32'(ifc.mem_req), 32'd1);
    chk("redir_addr", ifc.mem_addr, 32'h40);
    wait_hit("redir_hit");
    chk("redir_inst", ifc.instx, 32'h93001000);

    // Grant stall after byte 1 is issued.
    ifc.pcx = 32'h8;
    tick();
    chk("stall_addr0", ifc.mem_addr, 32'h8);
    tick();
    chk("stall_addr1", ifc.mem_addr, 32'h9);
    tick();
    ifc.mem_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall_req%0d", k), 32'(ifc.mem_req), 32'd1);
      chk($sformatf("stall_addr_hold%0d", k), ifc.mem_addr, 32'hA);
      tick();
    end
    ifc.mem_gnt = 1'b1;
    wait_hit("stall_hit");
    chk("stall_inst", ifc.instx, 32'hDEADBEEF);

    // rdy low blocks a new miss.
    rdy     = 1'b0;
    ifc.pcx = 32'hC;
    tick();
    chk("rdy_lo_req0", 32'(ifc.mem_req), 32'd0);
    tick();
    chk("rdy_lo_req1", 32'(ifc.mem_req), 32'd0);
    ifc.en_rx = 1'b0;
    rdy       = 1'b1;
    #1;
    chk("en_lo_hit", 32'(ifc.hitx), 32'd0);
    tick();
    chk("en_lo_req", 32'(ifc.mem_req), 32'd0);

    // Reset after two bytes are issued.
    ifc.en_rx = 1'b1;
    ifc.pcx   = 32'h10;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    ifc.en_rx = 1'b0;
    #1;
    chk("rstmid_req", 32'(ifc.mem_req), 32'd0);
    ifc.en_rx = 1'b1;
    ifc.pcx   = 32'h0;   #1; chk("rstmid_hit0",   32'(ifc.hitx), 32'd0);
    chk("rstmid_inst0", ifc.instx, 32'h0);
    ifc.pcx   = 32'h4;   #1; chk("rstmid_hit4",   32'(ifc.hitx), 32'd0);
    ifc.pcx   = 32'h8;   #1; chk("rstmid_hit8",   32'(ifc.hitx), 32'd0);
    ifc.pcx   = 32'h40;  #1; chk("rstmid_hit40",  32'(ifc.hitx), 32'd0);
    ifc.pcx   = 32'h200; #1; chk("rstmid_hit200", 32'(ifc.hitx), 32'd0);
    ifc.pcx   = 32'h0;
    tick();
    chk("refill_req", 32'(ifc.mem_req), 32'd1);
    chk("refill_addr", ifc.mem_addr, 32'h0);
    wait_hit("refill_hit");
    chk("refill_inst", ifc.instx, 32'h13050000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
